// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx #(
  parameter int DELAY_FRAMES    = 234,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] dataOut,
  input  logic       dataValid,
  output logic       txReady,
  output logic       fifoEmpty,
  output logic       txBusy,
  output logic       uartTx
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]              COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]              COUNT_ONE  = CW'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);
  localparam logic [12:0]                BAUD_LAST  = 13'(DELAY_FRAMES);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP_BIT  = 3'd4
  } txState_t;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA      = 3'd2,
    STOP_BIT  = 3'd3
  } txState_t;
`endif

  // ---------------- FIFO ----------------
  logic [7:0]                 fifoMem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wrPtrReg;
  logic [FIFO_DEPTH_LOG2-1:0] rdPtrReg;
  logic [CW-1:0]              countReg;
  logic [CW-1:0]              countNext;
  logic                       txReadyReg;
  logic                       fifoEmptyReg;
  logic                       push;
  logic                       popReq;
  logic [7:0]                 fifoHead;

  // Acceptance uses the registered full flag, so a pop in the same cycle cannot admit a write.
  assign push     = dataValid && txReadyReg;
  assign fifoHead = fifoMem[rdPtrReg];

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtrReg] <= dataOut;
    end
  end

  always_comb begin
    countNext = countReg;
    if (push && !popReq) begin
      countNext = countReg + COUNT_ONE;
    end else if (!push && popReq) begin
      countNext = countReg - COUNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtrReg     <= '0;
      rdPtrReg     <= '0;
      countReg     <= '0;
      txReadyReg   <= 1'b1;
      fifoEmptyReg <= 1'b1;
    end else begin
      if (push) begin
        wrPtrReg <= wrPtrReg + PTR_ONE;
      end
      if (popReq) begin
        rdPtrReg <= rdPtrReg + PTR_ONE;
      end
      countReg     <= countNext;
      txReadyReg   <= (countNext != COUNT_FULL);
      fifoEmptyReg <= (countNext == '0);
    end
  end

  // ---------------- Serializer ----------------
  txState_t    stateReg;
  txState_t    stateNext;
  logic [12:0] baudCntReg;
  logic [12:0] baudCntNext;
  logic [2:0]  bitCntReg;
  logic [2:0]  bitCntNext;
  logic [7:0]  shiftDataReg;
  logic [7:0]  shiftDataNext;
  logic        uartTxReg;
  logic        uartTxNext;
  logic        baudDone;
`ifdef UART_TX_PARITY_EN
  logic        parityReg;
  logic        parityNext;
`endif

  assign baudDone = (baudCntReg == BAUD_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateReg     <= IDLE;
      baudCntReg   <= '0;
      bitCntReg    <= '0;
      shiftDataReg <= '0;
      uartTxReg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parityReg    <= 1'b0;
`endif
    end else begin
      stateReg     <= stateNext;
      baudCntReg   <= baudCntNext;
      bitCntReg    <= bitCntNext;
      shiftDataReg <= shiftDataNext;
      uartTxReg    <= uartTxNext;
`ifdef UART_TX_PARITY_EN
      parityReg    <= parityNext;
`endif
    end
  end

  always_comb begin
    stateNext     = stateReg;
    baudCntNext   = baudCntReg;
    bitCntNext    = bitCntReg;
    shiftDataNext = shiftDataReg;
    uartTxNext    = uartTxReg;
    popReq        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parityNext    = parityReg;
`endif

    case (stateReg)
      IDLE: begin
        uartTxNext  = 1'b1;
        baudCntNext = '0;
        bitCntNext  = '0;
        popReq      = !fifoEmptyReg;
      end

      START_BIT: begin
        if (baudDone) begin
          uartTxNext  = shiftDataReg[0];
          baudCntNext = 13'd1;
          bitCntNext  = '0;
          stateNext   = DATA;
        end else begin
          baudCntNext = baudCntReg + 13'd1;
        end
      end

      DATA: begin
        if (baudDone) begin
          baudCntNext = 13'd1;
          if (bitCntReg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            uartTxNext = parityReg;
            stateNext  = PARITY;
`else
            uartTxNext = 1'b1;
            stateNext  = STOP_BIT;
`endif
          end else begin
            shiftDataNext = {1'b0, shiftDataReg[7:1]};
            uartTxNext    = shiftDataReg[1];
            bitCntNext    = bitCntReg + 3'd1;
          end
        end else begin
          baudCntNext = baudCntReg + 13'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baudDone) begin
          uartTxNext  = 1'b1;
          baudCntNext = 13'd1;
          stateNext   = STOP_BIT;
        end else begin
          baudCntNext = baudCntReg + 13'd1;
        end
      end
`endif

      STOP_BIT: begin
        if (baudDone) begin
          // A queued byte starts on the very next edge so frames stay contiguous.
          if (!fifoEmptyReg) begin
            popReq = 1'b1;
          end else begin
            stateNext   = IDLE;
            baudCntNext = '0;
          end
        end else begin
          baudCntNext = baudCntReg + 13'd1;
        end
      end

      default: begin
        stateNext   = IDLE;
        uartTxNext  = 1'b1;
        baudCntNext = '0;
      end
    endcase

    if (popReq) begin
      shiftDataNext = fifoHead;
      uartTxNext    = 1'b0;
      baudCntNext   = 13'd1;
      bitCntNext    = '0;
      stateNext     = START_BIT;
`ifdef UART_TX_PARITY_EN
      parityNext    = ^fifoHead;
`endif
    end
  end

  assign uartTx    = uartTxReg;
  assign txBusy    = (stateReg != IDLE);
  assign txReady   = txReadyReg;
  assign fifoEmpty = fifoEmptyReg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at DELAY_FRAMES=4, FIFO depth 4.
module tb_uart_tx;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR   = 1'b1;
  localparam int NBITS = 11;
`else
  localparam bit PAR   = 1'b0;
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * D;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       txReady;
  logic       fifoEmpty;
  logic       txBusy;
  logic       uartTx;

  uart_tx #(
    .DELAY_FRAMES   (D),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk      (clk),
    .resetN   (resetN),
    .dataOut  (dataOut),
    .dataValid(dataValid),
    .txReady  (txReady),
    .fifoEmpty(fifoEmpty),
    .txBusy   (txBusy),
    .uartTx   (uartTx)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  logic [511:0] capTx;
  logic [511:0] capBusy;
  logic         wrEn    [0:63];
  logic [7:0]   wrVal   [0:63];
  logic         readyAt [0:63];
  logic [63:0]  expV;
  logic [63:0]  expW;

  // Expected line level for one frame, one entry per clock, LSB = first cycle of start bit.
  function automatic logic [63:0] frameVec(input logic [7:0] b);
    logic [63:0] v;
    int k;
    v = '1;
    for (int i = 0; i < FL; i++) begin
      k = i / D;
      if (k == 0)              v[i] = 1'b0;
      else if (k <= 8)         v[i] = b[k-1];
      else if (PAR && k == 9)  v[i] = ^b;
      else                     v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic clearSeq();
    for (int i = 0; i < 64; i++) begin
      wrEn[i]  = 1'b0;
      wrVal[i] = 8'h00;
    end
  endtask

  // Drives one entry per cycle; entry i is sampled by the DUT at edge N+i.
  task automatic driveSeq(input int n);
    for (int i = 0; i < n; i++) begin
      dataValid  = wrEn[i];
      dataOut    = wrVal[i];
      readyAt[i] = txReady;
      @(posedge clk);
      #1;
    end
    dataValid = 1'b0;
  endtask

  // Sample j is taken 1 time unit after edge N+j.
  task automatic capture(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      capTx[j]   = uartTx;
      capBusy[j] = txBusy;
    end
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(posedge clk);
    #1;
    nCmp++; if (uartTx !== 1'b1)    begin nBad++; $display("FAIL reset_uartTx: got %b expected 1", uartTx); end
    nCmp++; if (txBusy !== 1'b0)    begin nBad++; $display("FAIL reset_txBusy: got %b expected 0", txBusy); end
    nCmp++; if (txReady !== 1'b1)   begin nBad++; $display("FAIL reset_txReady: got %b expected 1", txReady); end
    nCmp++; if (fifoEmpty !== 1'b1) begin nBad++; $display("FAIL reset_fifoEmpty: got %b expected 1", fifoEmpty); end
    resetN = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (uartTx !== 1'b1 || txBusy !== 1'b0 || txReady !== 1'b1 || fifoEmpty !== 1'b1) bad++;
    end
    nCmp++; if (bad !== 0) begin nBad++; $display("FAIL idle_hold: got %0d bad cycles expected 0", bad); end
    $display("reset: idle held for 100 cycles");
  endtask

  task automatic test_single();
    clearSeq();
    wrEn[0]  = 1'b1;
    wrVal[0] = 8'h55;
    fork
      driveSeq(1);
      capture(FL + 2);
    join
    expV = frameVec(8'h55);
    nCmp++; if (capTx[0] !== 1'b1)   begin nBad++; $display("FAIL single_no_early_start: got %b expected 1", capTx[0]); end
    nCmp++; if (capBusy[0] !== 1'b0) begin nBad++; $display("FAIL single_busy_at_write: got %b expected 0", capBusy[0]); end
    nCmp++; if (capTx[1 +: FL] !== expV[FL-1:0])
      begin nBad++; $display("FAIL single_frame55: got %h expected %h", capTx[1 +: FL], expV[FL-1:0]); end
    nCmp++; if (capBusy[FL] !== 1'b1)     begin nBad++; $display("FAIL single_busy_last_stop: got %b expected 1", capBusy[FL]); end
    nCmp++; if (capBusy[FL+1] !== 1'b0)   begin nBad++; $display("FAIL single_busy_drop: got %b expected 0", capBusy[FL+1]); end
    nCmp++; if (capTx[FL+1] !== 1'b1)     begin nBad++; $display("FAIL single_idle_after: got %b expected 1", capTx[FL+1]); end
    $display("single: byte 55 framed over %0d cycles", FL);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [0:4];
    bytes[0] = 8'hC5; bytes[1] = 8'hA3; bytes[2] = 8'h0F; bytes[3] = 8'hFF; bytes[4] = 8'h00;
    clearSeq();
    // C5 keeps the serializer busy so the burst below fills the FIFO.
    wrEn[0] = 1'b1; wrVal[0] = 8'hC5;
    wrEn[2] = 1'b1; wrVal[2] = 8'hA3;
    wrEn[3] = 1'b1; wrVal[3] = 8'h0F;
    wrEn[4] = 1'b1; wrVal[4] = 8'hFF;
    wrEn[5] = 1'b1; wrVal[5] = 8'h00;
    wrEn[6] = 1'b1; wrVal[6] = 8'h3C;
    fork
      driveSeq(7);
      capture(5 * FL + 2);
    join
    nCmp++; if (readyAt[5] !== 1'b1) begin nBad++; $display("FAIL b2b_ready_before_full: got %b expected 1", readyAt[5]); end
    nCmp++; if (readyAt[6] !== 1'b0) begin nBad++; $display("FAIL b2b_ready_when_full: got %b expected 0", readyAt[6]); end
    for (int k = 0; k < 5; k++) begin
      expV = frameVec(bytes[k]);
      nCmp++;
      if (capTx[1 + k*FL +: FL] !== expV[FL-1:0]) begin
        nBad++;
        $display("FAIL b2b_frame%0d: got %h expected %h", k, capTx[1 + k*FL +: FL], expV[FL-1:0]);
      end
      $display("b2b: frame %0d byte %02h checked", k, bytes[k]);
    end
    nCmp++; if (capBusy[5*FL] !== 1'b1)   begin nBad++; $display("FAIL b2b_busy_last_stop: got %b expected 1", capBusy[5*FL]); end
    nCmp++; if (capBusy[5*FL+1] !== 1'b0) begin nBad++; $display("FAIL b2b_dropped_byte_not_sent: got busy %b expected 0", capBusy[5*FL+1]); end
    nCmp++; if (capTx[5*FL+1] !== 1'b1)   begin nBad++; $display("FAIL b2b_idle_after: got %b expected 1", capTx[5*FL+1]); end
    nCmp++; if (fifoEmpty !== 1'b1)       begin nBad++; $display("FAIL b2b_fifo_empty: got %b expected 1", fifoEmpty); end
  endtask

  task automatic test_stop_boundary();
    clearSeq();
    wrEn[0]  = 1'b1; wrVal[0]  = 8'h42;
    wrEn[FL] = 1'b1; wrVal[FL] = 8'h81;
    fork
      driveSeq(FL + 1);
      capture(2 * FL + 2);
    join
    expV = frameVec(8'h42);
    expW = frameVec(8'h81);
    nCmp++; if (capTx[1 +: FL] !== expV[FL-1:0])
      begin nBad++; $display("FAIL boundary_frame42: got %h expected %h", capTx[1 +: FL], expV[FL-1:0]); end
    nCmp++; if (capTx[1 + FL +: FL] !== expW[FL-1:0])
      begin nBad++; $display("FAIL boundary_frame81: got %h expected %h", capTx[1 + FL +: FL], expW[FL-1:0]); end
    nCmp++; if (capBusy[FL+1] !== 1'b1)   begin nBad++; $display("FAIL boundary_no_idle_gap: got busy %b expected 1", capBusy[FL+1]); end
    nCmp++; if (capBusy[2*FL+1] !== 1'b0) begin nBad++; $display("FAIL boundary_busy_drop: got %b expected 0", capBusy[2*FL+1]); end
    $display("boundary: bytes 42 and 81 sent contiguously");
  endtask

  task automatic test_reset_midframe();
    int bad;
    clearSeq();
    wrEn[0] = 1'b1; wrVal[0] = 8'hF0;
    wrEn[1] = 1'b1; wrVal[1] = 8'h11;
    wrEn[2] = 1'b1; wrVal[2] = 8'h22;
    fork
      driveSeq(3);
      capture(19);
    join
    // Now inside data bit 3 of F0 (a zero bit), with two bytes still queued.
    nCmp++; if (uartTx !== 1'b0)    begin nBad++; $display("FAIL midframe_bit3: got %b expected 0", uartTx); end
    nCmp++; if (fifoEmpty !== 1'b0) begin nBad++; $display("FAIL midframe_queued: got %b expected 0", fifoEmpty); end
    #2 resetN = 1'b0;
    #1;
    nCmp++; if (uartTx !== 1'b1)    begin nBad++; $display("FAIL async_reset_uartTx: got %b expected 1", uartTx); end
    nCmp++; if (fifoEmpty !== 1'b1) begin nBad++; $display("FAIL async_reset_fifoEmpty: got %b expected 1", fifoEmpty); end
    nCmp++; if (txReady !== 1'b1)   begin nBad++; $display("FAIL async_reset_txReady: got %b expected 1", txReady); end
    nCmp++; if (txBusy !== 1'b0)    begin nBad++; $display("FAIL async_reset_txBusy: got %b expected 0", txBusy); end
    @(posedge clk);
    @(posedge clk);
    #1 resetN = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (uartTx !== 1'b1 || txBusy !== 1'b0) bad++;
    end
    nCmp++; if (bad !== 0) begin nBad++; $display("FAIL post_reset_silent: got %0d active cycles expected 0", bad); end
    $display("reset: frame F0 aborted, queue flushed");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] pb [0:1];
    logic       pexp [0:1];
    pb[0] = 8'h07; pexp[0] = 1'b1;
    pb[1] = 8'h03; pexp[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clearSeq();
      wrEn[0] = 1'b1; wrVal[0] = pb[k];
      fork
        driveSeq(1);
        capture(FL + 2);
      join
      nCmp++; if (capTx[1 + 9*D] !== pexp[k])
        begin nBad++; $display("FAIL parity_bit_%02h: got %b expected %b", pb[k], capTx[1 + 9*D], pexp[k]); end
      nCmp++; if (capBusy[FL] !== 1'b1 || capBusy[FL+1] !== 1'b0)
        begin nBad++; $display("FAIL parity_frame_len_%02h: got busy %b%b expected 10", pb[k], capBusy[FL], capBusy[FL+1]); end
      $display("parity: byte %02h sent", pb[k]);
    end
  endtask
`endif

  initial begin
    resetN    = 1'b0;
    dataValid = 1'b0;
    dataOut   = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_stop_boundary();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
